fp_mult_stim_gen: RTL

- Self-sequencing stimulus driver for the fp_mult pipeline. It issues IEEE-754 single-precision operand pairs (a, b) covering the corner-case classes, one pair per cycle.
- It aligns the returned z/status with each pair's class tag after the multiplier's fixed latency.
- Sits on the input side of the multiplier, opposite the status/result checkers, so benches and on-chip self-test can drive the multiplier exhaustively by class.

---
 rtl/fp_mult_stim_gen.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_mult_stim_gen.sv
// Class-sweeping operand generator for the fp_mult pipeline, with result/tag realignment.
// Optional result scoreboard compiled in with `define STIM_SCOREBOARD_EN.
module fp_mult_stim_gen #(
    parameter int          PIPE_LAT   = 3,
    parameter int          NUM_ROUNDS = 4,
    parameter logic [31:0] LFSR_SEED  = 32'hACE12468
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic        op_valid,
    input  logic [31:0] z,
    input  logic [7:0]  status,
    output logic        res_valid,
    output logic [3:0]  res_class,
    output logic [31:0] res_z,
    output logic [7:0]  res_status,
    output logic        busy,
    output logic        done,
    output logic [15:0] vec_count,
    output logic [15:0] err_count
);

    localparam logic [31:0] TAPS = 32'h80200003;
    localparam logic [31:0] SEED = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] lfsr_reg, lfsr_next;
    logic [3:0]  class_idx_reg, class_idx_next;
    logic [15:0] round_cnt_reg, round_cnt_next;
    logic [7:0]  drain_cnt_reg, drain_cnt_next;
    logic        emit;
    logic [3:0]  emit_class;
    logic        clear_run;

    logic [31:0] a_reg, b_reg;
    logic        op_valid_reg;
    logic [15:0] vec_count_reg;
    logic        res_valid_reg;
    logic [3:0]  res_class_reg;
    logic [31:0] res_z_reg;
    logic [7:0]  res_status_reg;

    logic [31:0] vec_a, vec_b, vec_x, vec_y;
    logic        swap_ok;

    // Clamp the exponent into the normal range so the operand is a finite normal.
    function automatic logic [30:0] norm_mag(input logic [30:0] src);
        logic [7:0] e;
        e = src[30:23];
        if (e == 8'h00)
            e = 8'h01;
        else if (e == 8'hFF)
            e = 8'hFE;
        return {e, src[22:0]};
    endfunction

    assign lfsr_next = lfsr_reg[0] ? ({1'b0, lfsr_reg[31:1]} ^ TAPS) : {1'b0, lfsr_reg[31:1]};

    // class_idx_reg/round_cnt_reg describe the vector currently on a/b; emit_class is the one being loaded.
    always_comb begin
        state_next     = state_reg;
        class_idx_next = class_idx_reg;
        round_cnt_next = round_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        emit           = 1'b0;
        emit_class     = 4'd0;
        clear_run      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next     = S_ISSUE;
                    emit           = 1'b1;
                    emit_class     = 4'd0;
                    class_idx_next = 4'd0;
                    round_cnt_next = 16'd0;
                    clear_run      = 1'b1;
                end
            end
            S_ISSUE: begin
                if (class_idx_reg == 4'd8 && round_cnt_reg == 16'(NUM_ROUNDS - 1)) begin
                    state_next     = S_DRAIN;
                    drain_cnt_next = 8'd0;
                end else begin
                    emit = 1'b1;
                    if (class_idx_reg == 4'd8) begin
                        emit_class     = 4'd0;
                        round_cnt_next = round_cnt_reg + 16'd1;
                    end else begin
                        emit_class = class_idx_reg + 4'd1;
                    end
                    class_idx_next = emit_class;
                end
            end
            S_DRAIN: begin
                // PIPE_LAT drain cycles put done on the same cycle as the final aligned result.
                if (drain_cnt_reg == 8'(PIPE_LAT - 1))
                    state_next = S_DONE;
                else
                    drain_cnt_next = drain_cnt_reg + 8'd1;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // First operand takes sign L[1], second takes L[0]; class 8 keeps the raw LFSR bits.
    always_comb begin
        vec_x   = 32'd0;
        vec_y   = 32'd0;
        swap_ok = 1'b0;
        case (emit_class)
            4'd0: begin
                vec_x   = {lfsr_reg[1], 31'd0};
                vec_y   = {lfsr_reg[0], norm_mag(lfsr_reg[30:0])};
                swap_ok = 1'b1;
            end
            4'd1: begin
                vec_x = {lfsr_reg[1], norm_mag(lfsr_reg[30:0])};
                vec_y = {lfsr_reg[0], norm_mag({lfsr_reg[14:0], lfsr_reg[31:16]})};
            end
            4'd2: begin
                vec_x   = {lfsr_reg[1], 8'hFF, 23'd0};
                vec_y   = {lfsr_reg[0], norm_mag(lfsr_reg[30:0])};
                swap_ok = 1'b1;
            end
            4'd3: begin
                vec_x   = {lfsr_reg[1], 31'd0};
                vec_y   = {lfsr_reg[0], 8'hFF, 23'd0};
                swap_ok = 1'b1;
            end
            4'd4: begin
                vec_x   = {lfsr_reg[1], 8'hFF, lfsr_reg[22:0] | 23'd1};
                vec_y   = {lfsr_reg[0], norm_mag(lfsr_reg[30:0])};
                swap_ok = 1'b1;
            end
            4'd5: begin
                vec_x = {lfsr_reg[1], 31'h7F7FFFFF};
                vec_y = {lfsr_reg[0], 31'h7F7FFFFF};
            end
            4'd6: begin
                vec_x = {lfsr_reg[1], 31'h00800000};
                vec_y = {lfsr_reg[0], 31'h00800000};
            end
            4'd7: begin
                vec_x   = {lfsr_reg[1], 8'h00, lfsr_reg[22:0] | 23'd1};
                vec_y   = {lfsr_reg[0], norm_mag(lfsr_reg[30:0])};
                swap_ok = 1'b1;
            end
            default: begin
                vec_x = lfsr_reg;
                vec_y = ~lfsr_reg;
            end
        endcase
        if (swap_ok && lfsr_reg[31]) begin
            vec_a = vec_y;
            vec_b = vec_x;
        end else begin
            vec_a = vec_x;
            vec_b = vec_y;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            lfsr_reg      <= SEED;
            class_idx_reg <= 4'd0;
            round_cnt_reg <= 16'd0;
            drain_cnt_reg <= 8'd0;
            a_reg         <= 32'd0;
            b_reg         <= 32'd0;
            op_valid_reg  <= 1'b0;
            vec_count_reg <= 16'd0;
        end else begin
            state_reg     <= state_next;
            class_idx_reg <= class_idx_next;
            round_cnt_reg <= round_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            op_valid_reg  <= emit;
            if (emit) begin
                a_reg    <= vec_a;
                b_reg    <= vec_b;
                lfsr_reg <= lfsr_next;
            end
            if (clear_run)
                vec_count_reg <= 16'd0;
            else if (op_valid_reg && vec_count_reg != 16'hFFFF)
                vec_count_reg <= vec_count_reg + 16'd1;
        end
    end

    // Tag delay line: stage PIPE_LAT-1 lines up with z/status of the same vector.
    logic [PIPE_LAT-1:0]      tag_valid_reg, tag_valid_in;
    logic [PIPE_LAT-1:0][3:0] tag_class_reg, tag_class_in;

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_valid_in[gi] = op_valid_reg;
                assign tag_class_in[gi] = class_idx_reg;
            end else begin : g_body
                assign tag_valid_in[gi] = tag_valid_reg[gi-1];
                assign tag_class_in[gi] = tag_class_reg[gi-1];
            end
        end
    endgenerate

    logic       head_valid;
    logic [3:0] head_class;
    assign head_valid = tag_valid_reg[PIPE_LAT-1];
    assign head_class = tag_class_reg[PIPE_LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_valid_reg  <= '0;
            tag_class_reg  <= '0;
            res_valid_reg  <= 1'b0;
            res_class_reg  <= 4'd0;
            res_z_reg      <= 32'd0;
            res_status_reg <= 8'd0;
        end else begin
            tag_valid_reg <= tag_valid_in;
            tag_class_reg <= tag_class_in;
            res_valid_reg <= head_valid;
            if (head_valid) begin
                res_class_reg  <= head_class;
                res_z_reg      <= z;
                res_status_reg <= status;
            end
        end
    end

`ifdef STIM_SCOREBOARD_EN
    // status = {overflow, underflow, zero_f, inf_f, nan_f, tiny_f, huge_f, inexact_f}
    logic        sb_fail;
    logic [15:0] err_count_reg;

    always_comb begin
        sb_fail = 1'b0;
        case (head_class)
            4'd0:       sb_fail = !status[5];
            4'd2:       sb_fail = !status[4];
            4'd3, 4'd4: sb_fail = !status[3];
            4'd5:       sb_fail = !status[7];
            4'd6:       sb_fail = !status[6];
            default:    sb_fail = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_count_reg <= 16'd0;
        else if (clear_run)
            err_count_reg <= 16'd0;
        else if (head_valid && sb_fail && err_count_reg != 16'hFFFF)
            err_count_reg <= err_count_reg + 16'd1;
    end

    assign err_count = err_count_reg;
`else
    assign err_count = 16'd0;
`endif

    assign a          = a_reg;
    assign b          = b_reg;
    assign op_valid   = op_valid_reg;
    assign res_valid  = res_valid_reg;
    assign res_class  = res_class_reg;
    assign res_z      = res_z_reg;
    assign res_status = res_status_reg;
    assign vec_count  = vec_count_reg;
    assign busy       = (state_reg == S_ISSUE) || (state_reg == S_DRAIN);
    assign done       = (state_reg == S_DONE);

endmodule
